// File: rtl/seq_multiplier.sv
// Sequential shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH, with start/done handshake.
// Signed operands are multiplied as magnitudes; the sign is applied once in FIX.
module seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   BR,
    input  logic [WIDTH-1:0]   AR,
    output logic [2*WIDTH-1:0] PR,
    output logic               busy,
    output logic               done
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    pr_q, pr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             neg_q, neg_d;
    logic [WIDTH:0]   sum;

    // The most-negative operand maps to 2^(WIDTH-1), which still fits unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
    endfunction

    function automatic logic [PW-1:0] negate(input logic [PW-1:0] v);
        return ~v + PW'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            pr_q     <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            pr_q     <= pr_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        pr_d     = pr_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        sum      = '0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    mcand_d  = magnitude(BR, signed_mode);
                    mplier_d = magnitude(AR, signed_mode);
                    neg_d    = signed_mode & (BR[WIDTH-1] ^ AR[WIDTH-1]);
                    acc_d    = '0;
                    cnt_d    = CW'(WIDTH);
                    state_d  = CALC;
                end else begin
                    state_d  = IDLE;
                end
            end
            CALC: begin
                // Carry out of the upper-half add becomes the new MSB after the shift.
                sum      = {1'b0, acc_q[PW-1:WIDTH]} + {1'b0, (mplier_q[0] ? mcand_q : '0)};
                acc_d    = {sum, acc_q[WIDTH-1:1]};
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                pr_d    = neg_q ? negate(acc_q) : acc_q;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign PR   = pr_q;
    assign busy = (state_q == CALC) || (state_q == FIX);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: WIDTH=8 instance checked every cycle, WIDTH=16 spot checks.
module tb_seq_multiplier;
    localparam int W  = 8;
    localparam int W2 = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic              start, sm;
    logic [W-1:0]      br, ar;
    logic [2*W-1:0]    pr;
    logic              busy, done;

    logic              start2, sm2;
    logic [W2-1:0]     br2, ar2;
    logic [2*W2-1:0]   pr2;
    logic              busy2, done2;

    seq_multiplier #(.WIDTH(W)) dut8 (
        .clk(clk), .rst(rst), .start(start), .signed_mode(sm),
        .BR(br), .AR(ar), .PR(pr), .busy(busy), .done(done)
    );

    seq_multiplier #(.WIDTH(W2)) dut16 (
        .clk(clk), .rst(rst), .start(start2), .signed_mode(sm2),
        .BR(br2), .AR(ar2), .PR(pr2), .busy(busy2), .done(done2)
    );

    typedef struct {
        logic [2*W-1:0] exp;
        int             k;
    } item_t;

    item_t q[$];
    int    cyc    = 0;
    int    errors = 0;
    int    checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [63:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
        longint x, y;
        x = longint'(a);
        y = longint'(b);
        if (s && a[w-1]) x = x - (longint'(1) << w);
        if (s && b[w-1]) y = y - (longint'(1) << w);
        return 64'(x * y) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    // Cycle-accurate expectation of busy/done from the oldest outstanding operation.
    always @(negedge clk) begin : mon
        bit mb, md;
        int d;
        if (!rst) begin
            mb = 1'b0;
            md = 1'b0;
            if (q.size() > 0) begin
                d  = cyc - q[0].k;
                mb = (d >= 0) && (d <= W);
                md = (d == W + 1);
            end
            check("busy", 64'(busy), 64'(mb));
            check("done", 64'(done), 64'(md));
            if (md) begin
                check("PR", 64'(pr), 64'(q[0].exp));
                void'(q.pop_front());
            end
        end
    end

    task automatic go(input logic [W-1:0] b, input logic [W-1:0] a, input logic s,
                      input logic [2*W-1:0] e);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        br    = b;
        ar    = a;
        sm    = s;
        start = 1'b1;
        @(posedge clk);
        q.push_back('{e, cyc + 1});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (q.size() > 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (q.size() > 0) begin
            check("drain_timeout", 64'(q.size()), 64'd0);
            q.delete();
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 30);
        if (!done) check("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic go16(input logic [W2-1:0] b, input logic [W2-1:0] a, input logic s,
                        input logic [2*W2-1:0] e);
        int k, n;
        @(negedge clk);
        br2    = b;
        ar2    = a;
        sm2    = s;
        start2 = 1'b1;
        @(posedge clk);
        k = cyc + 1;
        @(negedge clk);
        start2 = 1'b0;
        n = 0;
        while (!done2 && n < 40) begin
            check("busy16", 64'(busy2), 64'd1);
            @(negedge clk);
            n++;
        end
        check("lat16", 64'(cyc - k), 64'(W2 + 1));
        check("PR16", 64'(pr2), 64'(e));
    endtask

    logic [W-1:0]   tb_b [5] = '{8'hAA, 8'h80, 8'hFF, 8'hFF, 8'h00};
    logic [W-1:0]   tb_a [5] = '{8'hCC, 8'h80, 8'h01, 8'hFF, 8'hB7};
    logic           tb_s [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [2*W-1:0] tb_e [5] = '{16'h1178, 16'h4000, 16'hFFFF, 16'hFE01, 16'h0000};

    initial begin
        logic [W-1:0] rb, ra;
        logic         rs;
        int           n;

        rst = 1'b1; start = 1'b0; sm = 1'b0; br = '0; ar = '0;
        start2 = 1'b0; sm2 = 1'b0; br2 = '0; ar2 = '0;
        repeat (2) @(negedge clk);
        check("rst_PR", 64'(pr), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_PR16", 64'(pr2), 64'd0);
        rst = 1'b0;

        go(8'hAA, 8'hCC, 1'b0, 16'h8778);
        wait_idle();
        for (int i = 0; i < 5; i++) go(tb_b[i], tb_a[i], tb_s[i], tb_e[i]);
        wait_idle();

        for (int i = 0; i < 16; i++) begin
            rb = W'($urandom);
            ra = W'($urandom);
            rs = 1'($urandom);
            go(rb, ra, rs, (2*W)'(model(W, 32'(rb), 32'(ra), rs)));
        end
        wait_idle();

        // Starts while busy must be ignored; the captured operands decide the result.
        go(8'h9C, 8'h3B, 1'b1, (2*W)'(model(W, 32'h9C, 32'h3B, 1'b1)));
        for (int j = 0; j < W; j++) begin
            start = 1'b1;
            br    = W'($urandom);
            ar    = W'($urandom);
            sm    = 1'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        wait_idle();

        // Start held high, new operands presented at each DONE.
        @(negedge clk);
        rb = 8'h37; ra = 8'hE9; rs = 1'b0;
        br = rb; ar = ra; sm = rs; start = 1'b1;
        @(posedge clk);
        q.push_back('{(2*W)'(model(W, 32'(rb), 32'(ra), rs)), cyc + 1});
        for (int i = 0; i < 4; i++) begin
            wait_done(n);
            rb = W'($urandom); ra = W'($urandom); rs = 1'(i);
            br = rb; ar = ra; sm = rs;
            @(posedge clk);
            q.push_back('{(2*W)'(model(W, 32'(rb), 32'(ra), rs)), cyc + 1});
        end
        wait_done(n);
        start = 1'b0;
        wait_idle();

        // Asynchronous reset mid-CALC aborts the operation.
        go(8'h12, 8'h34, 1'b0, 16'h03A8);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_PR", 64'(pr), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        q.delete();
        @(negedge clk);
        #2 rst = 1'b0;
        go(8'h12, 8'h34, 1'b0, 16'h03A8);
        wait_idle();

        go16(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001);
        go16(16'h8000, 16'h7FFF, 1'b1, 32'hC0008000);
        go16(16'h8000, 16'h8000, 1'b1, 32'h40000000);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
